// File: rtl/fmul_arbiter_pkg.sv
// fmul_arb_pkg: shared types and constants for the float32 multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fmul_arb_pkg;

  localparam int FP32_W = 32;

  // Scale constants used by the preprocessing engines that share the multiplier.
  localparam logic [FP32_W-1:0] FP32_ONE        = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP32_SCALE_2M15 = 32'h3800_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fmul_arbiter_rr_picker.sv
// rr_picker: combinational one-hot winner selection over a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the winner simply follows req_i.
//
// Build option FMUL_ARB_RR_EN: when defined, the search starts one past ptr_i
// (round-robin); otherwise the lowest requesting index wins and ptr_i is absent.
//
// Ports:
//   req_i    - per-requester request bits
//   ptr_i    - index of the last winner (round-robin build only)
//   win_oh_o - one-hot winner, all zero when no request
//   win_id_o - binary index of the winner, zero when no request
module rr_picker
  import fmul_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
`ifdef FMUL_ARB_RR_EN
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
`endif
  output logic [N_REQ-1:0]         win_oh_o,
  output logic [$clog2(N_REQ)-1:0] win_id_o
);

  localparam int IDW = $clog2(N_REQ);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    win_oh_o = '0;
    win_id_o = '0;
    found    = 1'b0;
    idx      = '0;
`ifdef FMUL_ARB_RR_EN
    // Visit ptr+1, ptr+2, ... wrapping, so the last winner is checked last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(ptr_i) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_id_o      = idx;
      end
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDW'(i);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_id_o      = idx;
      end
    end
`endif
  end

endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one combinational float32 multiplier among N_REQ requesters.
// Latency: accept at posedge T, product strobed T+MUL_LATENCY..T+MUL_LATENCY+1; MUL_LATENCY+2 cycles per op.
// Backpressure: req_ready is zero while an operation is in flight; waiting requesters hold valid.
//
// Build option FMUL_ARB_RR_EN: round-robin arbitration when defined, fixed
// priority (lowest index wins) otherwise.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/a/b        - per-requester operand pairs, requester k at [k*DATA_W +: DATA_W]
//   req_ready            - one-hot accept, only in IDLE
//   rsp_valid, rsp_data  - one-cycle one-hot product strobe and product
//   mul_a, mul_b, mul_out- connection to the shared multiplier
//   busy, grant_id       - operation in flight, current/last granted requester
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 10,
  parameter int DATA_W      = FP32_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_out,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int             IDW      = $clog2(N_REQ);
  localparam int             CNTW     = $clog2(MUL_LATENCY + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MUL_LATENCY - 1);

  arb_state_e         state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [IDW-1:0]     grant_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [DATA_W-1:0]  mul_a_q;
  logic [DATA_W-1:0]  mul_b_q;
  logic               busy_q;

  logic [N_REQ-1:0]   win_oh;
  logic [IDW-1:0]     win_id;
  logic               accept;

`ifdef FMUL_ARB_RR_EN
  logic [IDW-1:0]     ptr_q;
`endif

  rr_picker #(
    .N_REQ    (N_REQ)
  ) u_picker (
    .req_i    (req_valid),
`ifdef FMUL_ARB_RR_EN
    .ptr_i    (ptr_q),
`endif
    .win_oh_o (win_oh),
    .win_id_o (win_id)
  );

  // Ready only in IDLE; held low while reset is asserted so nothing is taken then.
  assign req_ready = (state_q == IDLE && !rst) ? win_oh : '0;
  assign accept    = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
`ifdef FMUL_ARB_RR_EN
      // Pointing at the last requester makes requester 0 the first winner.
      ptr_q       <= IDW'(N_REQ - 1);
`endif
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mul_a_q <= req_a[win_id*DATA_W +: DATA_W];
            mul_b_q <= req_b[win_id*DATA_W +: DATA_W];
            grant_q <= win_id;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= HOLD;
`ifdef FMUL_ARB_RR_EN
            ptr_q   <= win_id;
`endif
          end
        end
        HOLD: begin
          // Operands have been on the multiplier for MUL_LATENCY cycles at this edge.
          if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= mul_out;
            rsp_valid_q <= N_REQ'(1) << grant_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter with a transaction-level reference model
// and a response scoreboard.
module tb_fmul_arbiter;

  localparam int N = 4;
  localparam int L = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [31:0]   rsp_data, mul_a, mul_b, mul_out;
  logic          busy;
  logic [1:0]    grant_id;

  int tests = 0;
  int fails = 0;

  // Simple float32 multiply for normal operands (truncating), standing in for FLOAT32_MUL.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  assign mul_out = fmul(mul_a, mul_b);

  fmul_arbiter #(.N_REQ(N), .MUL_LATENCY(L), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Reference arbitration rule: which requester wins given the valid set and last winner.
  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef FMUL_ARB_RR_EN
    for (int i = 1; i <= N; i++) if (v[(p + i) % N]) return (p + i) % N;
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t cur, e;
  bit   inf = 0;
  bit   mon_en = 0;
  bit   prev_rst = 1;
  int   next_acc = 0;
  int   ptr = N - 1;
  int   k, w;
  logic [N-1:0] er;
  logic [N-1:0] hs_vec = '0;
  int   acc_id[$];
  int   acc_t[$];
  int   rsp_cnt = 0;
  logic [31:0] last_rsp_data = '0;

  // Monitor: checks outputs produced by the previous posedge, then advances the model.
  always @(negedge clk) begin
    if (mon_en) begin
      k = cyc;
      if (prev_rst) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
      end else begin
        chk("busy", busy, (inf && k >= cur.t && k <= cur.t + L) ? 1 : 0);
        if (inf && k >= cur.t && k <= cur.t + L) begin
          chk("mul_a_hold", mul_a, cur.a);
          chk("mul_b_hold", mul_b, cur.b);
          chk("grant_id", grant_id, cur.id);
        end
        if (rsp_valid != '0) begin
          rsp_cnt++;
          last_rsp_data = rsp_data;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, k);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, 4'b0001 << e.id);
            chk("rsp_data", rsp_data, e.p);
            chk("rsp_latency", 64'(k - e.t), L);
          end
        end else if (sb.size() > 0 && k > sb[0].t + L) begin
          tests++;
          fails++;
          $display("FAIL rsp_missing: no rsp for requester %0d accepted at %0d (cycle %0d)", sb[0].id, sb[0].t, k);
          void'(sb.pop_front());
        end
      end

      er = '0;
      w  = pick(req_valid, ptr);
      if (!rst && k + 1 >= next_acc && w >= 0) er[w] = 1'b1;
      chk("req_ready", req_ready, er);

      hs_vec = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs_vec[i]) begin
          acc_id.push_back(i);
          acc_t.push_back(k + 1);
          break;
        end
      end

      if (rst) begin
        sb.delete();
        inf = 0;
        next_acc = 0;
        ptr = N - 1;
      end else if (er != '0) begin
        cur.id = w;
        cur.a  = req_a[w*32 +: 32];
        cur.b  = req_b[w*32 +: 32];
        cur.p  = fmul(cur.a, cur.b);
        cur.t  = k + 1;
        sb.push_back(cur);
        inf = 1;
        next_acc = k + 1 + L + 2;
`ifdef FMUL_ARB_RR_EN
        ptr = w;
`endif
      end
      prev_rst = rst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // mode 0: accepted requesters drop; 1: re-arm at once with new operands; 2: random traffic
  task automatic step_rearm(input int mode);
    step();
    for (int i = 0; i < N; i++) begin
      if (hs_vec[i]) begin
        if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) set_req(i, rnd_fp(), rnd_fp());
        else req_valid[i] = 1'b0;
      end else if (mode == 2) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 2) set_req(i, rnd_fp(), rnd_fp());
        else if (req_valid[i] && $urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) step();
    rst = 1'b0;
    acc_id.delete();
    acc_t.delete();
  endtask

  int exp_ids[5];
  int t0;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    step();
    mon_en = 1;
    do_reset();

    // Single request from requester 2: 1.0 * 2.0.
    set_req(2, 32'h3F80_0000, 32'h4000_0000);
    for (int n = 0; n < 20; n++) step_rearm(0);
    chk("single_count", acc_id.size(), 1);
    if (acc_id.size() > 0) chk("single_id", acc_id[0], 2);
    chk("single_product", last_rsp_data, 32'h4000_0000);

    // All requesters valid continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp());
    for (int n = 0; n < 80 && acc_id.size() < 5; n++) step_rearm(1);
`ifdef FMUL_ARB_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
`endif
    chk("contend_count", acc_id.size(), 5);
    for (int i = 0; i < 5 && i < acc_id.size(); i++) chk("contend_grant", acc_id[i], exp_ids[i]);
    for (int i = 1; i < acc_t.size(); i++) chk("contend_spacing", 64'(acc_t[i] - acc_t[i-1]), L + 2);
    req_valid = '0;
    repeat (14) step();

    // Reset in the middle of HOLD aborts the operation.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp());
    for (int n = 0; n < 6 && acc_id.size() == 0; n++) step_rearm(1);
    chk("abort_first_accept", acc_id.size(), 1);
    if (acc_id.size() > 0) begin
      t0 = acc_t[0];
      while (cyc < t0 + 5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      acc_id.delete();
      acc_t.delete();
      rsp_cnt = 0;
      for (int n = 0; n < 8; n++) step_rearm(1);
      chk("abort_no_rsp", rsp_cnt, 0);
      chk("abort_restart_count", acc_id.size(), 1);
      if (acc_id.size() > 0) chk("abort_restart_id", acc_id[0], 0);
    end
    req_valid = '0;
    repeat (14) step();

    // A request raised during RESP waits for the next IDLE cycle.
    do_reset();
    set_req(1, rnd_fp(), rnd_fp());
    for (int n = 0; n < 4 && acc_id.size() == 0; n++) step_rearm(0);
    chk("resp_first_accept", acc_id.size(), 1);
    if (acc_id.size() > 0) begin
      t0 = acc_t[0];
      while (cyc < t0 + L) step_rearm(0);
      set_req(3, rnd_fp(), rnd_fp());
      chk("resp_cycle_strobe", rsp_valid, 4'b0010);
      chk("resp_cycle_no_ready", req_ready, 0);
      for (int n = 0; n < 4 && acc_id.size() < 2; n++) step_rearm(0);
      chk("resp_late_count", acc_id.size(), 2);
      if (acc_id.size() > 1) begin
        chk("resp_late_id", acc_id[1], 3);
        chk("resp_late_time", 64'(acc_t[1] - t0), L + 2);
      end
    end
    repeat (14) step_rearm(0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) step_rearm(2);
    req_valid = '0;
    repeat (16) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
